mem_arbiter: RTL and testbench

Two-into-one arbiter sharing the single memory bus between the instruction-fetch requester and the data-memory requester. It latches the winning request into registered downstream outputs and carries it through the split address/data handshake (valid → addr_ok → data_ok). It returns the response to the granted requester only. It sits between the IF and MEM stages and the memory-side bus port.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-into-one memory bus arbiter: IF fetch vs MEM data, registered downstream request,
// split address/data handshake. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [63:0] rdata,
    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [63:0] m_rdata,
    output logic        grant_d,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic [63:0] m_addr_q, m_addr_d;
    logic [2:0]  m_size_q, m_size_d;
    logic [7:0]  m_strobe_q, m_strobe_d;
    logic [63:0] m_wdata_q, m_wdata_d;
    logic        i_addr_ok_q, i_addr_ok_d;
    logic        d_addr_ok_q, d_addr_ok_d;
    logic        grant_d_q, grant_d_d;
    logic        pick_d;
    logic        done;

`ifdef MEM_ARB_RR_EN
    // 1 = data won the most recent grant; reset means "last = fetch" so the first tie goes to data
    logic        rr_last_d_q, rr_last_d_d;

    always_comb begin
        pick_d      = d_valid && (!i_valid || !rr_last_d_q);
        rr_last_d_d = rr_last_d_q;
        if (state_q == IDLE && (i_valid || d_valid))
            rr_last_d_d = pick_d;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_last_d_q <= 1'b0;
        else     rr_last_d_q <= rr_last_d_d;
    end
`else
    always_comb pick_d = d_valid;
`endif

    // Response completes either straight out of REQ (address and data in one cycle) or from RESP
    assign done = (state_q == REQ && m_addr_ok && m_data_ok) || (state_q == RESP && m_data_ok);

    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_addr_d    = m_addr_q;
        m_size_d    = m_size_q;
        m_strobe_d  = m_strobe_q;
        m_wdata_d   = m_wdata_q;
        grant_d_d   = grant_d_q;
        i_addr_ok_d = 1'b0;
        d_addr_ok_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d     = REQ;
                    m_valid_d   = 1'b1;
                    grant_d_d   = pick_d;
                    i_addr_ok_d = !pick_d;
                    d_addr_ok_d = pick_d;
                    if (pick_d) begin
                        m_addr_d   = d_addr;
                        m_size_d   = d_size;
                        m_strobe_d = d_strobe;
                        m_wdata_d  = d_wdata;
                    end else begin
                        m_addr_d   = i_addr;
                        m_size_d   = 3'b010;
                        m_strobe_d = 8'h00;
                        m_wdata_d  = 64'h0;
                    end
                end
            end
            REQ: begin
                if (m_addr_ok) begin
                    m_valid_d = 1'b0;
                    state_d   = m_data_ok ? IDLE : RESP;
                end
            end
            RESP: begin
                if (m_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_addr_q    <= 64'h0;
            m_size_q    <= 3'b000;
            m_strobe_q  <= 8'h00;
            m_wdata_q   <= 64'h0;
            i_addr_ok_q <= 1'b0;
            d_addr_ok_q <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_size_q    <= m_size_d;
            m_strobe_q  <= m_strobe_d;
            m_wdata_q   <= m_wdata_d;
            i_addr_ok_q <= i_addr_ok_d;
            d_addr_ok_q <= d_addr_ok_d;
            grant_d_q   <= grant_d_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_size    = m_size_q;
    assign m_strobe  = m_strobe_q;
    assign m_wdata   = m_wdata_q;
    assign i_addr_ok = i_addr_ok_q;
    assign d_addr_ok = d_addr_ok_q;
    assign grant_d   = grant_d_q;
    assign busy      = (state_q != IDLE);
    assign i_data_ok = done && !grant_d_q;
    assign d_data_ok = done && grant_d_q;
    assign rdata     = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of requests, downstream latency model, and a
// scoreboard queue of expected grants/responses in arbitration order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [2:0]  d_size = '0;
    logic [7:0]  d_strobe = '0;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [63:0] rdata, m_addr, m_wdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic        m_valid, grant_d, busy;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .rdata(rdata), .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata), .grant_d(grant_d), .busy(busy)
    );

    typedef struct {
        logic        g_d;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic [63:0] da;
        logic [2:0]  dsize;
        logic [7:0]  dstb;
        logic [63:0] dwd;
        int          alat;
        int          dlat;
        logic [63:0] rd_i;
        logic [63:0] rd_d;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   errs = 0;
    int   checks = 0;
    logic last_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_i(input logic [63:0] a, input logic [63:0] rd);
        exp_t e;
        e.g_d = 1'b0; e.addr = a; e.size = 3'b010; e.strobe = 8'h00; e.wdata = 64'h0; e.rdata = rd;
        return e;
    endfunction

    function automatic exp_t mk_d(input vec_t v);
        exp_t e;
        e.g_d = 1'b1; e.addr = v.da; e.size = v.dsize; e.strobe = v.dstb; e.wdata = v.dwd; e.rdata = v.rd_d;
        return e;
    endfunction

    // Drive the requests of one vector and queue the expected grants in order
    task automatic push_req(input vec_t v);
        logic first_d;
        exp_t ei, ed;
        ei = mk_i(v.ia, v.rd_i);
        ed = mk_d(v);
        i_valid = v.iv; i_addr = v.ia;
        d_valid = v.dv; d_addr = v.da; d_size = v.dsize; d_strobe = v.dstb; d_wdata = v.dwd;
        if (v.iv && v.dv) begin
`ifdef MEM_ARB_RR_EN
            first_d = !last_d;
`else
            first_d = 1'b1;
`endif
            if (first_d) begin sb.push_back(ed); sb.push_back(ei); last_d = 1'b0; end
            else         begin sb.push_back(ei); sb.push_back(ed); last_d = 1'b1; end
        end else if (v.dv) begin
            sb.push_back(ed); last_d = 1'b1;
        end else if (v.iv) begin
            sb.push_back(ei); last_d = 1'b0;
        end
    endtask

    // Play the downstream and requesters until every queued transaction has completed
    task automatic run(input int alat, input int dlat);
        int   a_cnt = -1;
        int   d_cnt = -1;
        int   budget = 0;
        logic pv = 1'b0;
        logic pdok = 1'b0;
        while ((sb.size() != 0 || i_valid || d_valid) && budget < 80) begin
            @(negedge clk);
            budget++;
            m_addr_ok = 1'b0;
            m_data_ok = 1'b0;
            if (pdok) begin
                chk("idle_after_dok", {m_valid, busy}, 2'b00);
            end
            if (i_addr_ok || d_addr_ok) chk("addr_ok_onehot", i_addr_ok & d_addr_ok, 0);
            if (m_valid && !pv) begin
                if (sb.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    chk("grant_d", grant_d, sb[0].g_d);
                    chk("m_addr", m_addr, sb[0].addr);
                    chk("m_size", m_size, sb[0].size);
                    chk("m_strobe", m_strobe, sb[0].strobe);
                    chk("m_wdata", m_wdata, sb[0].wdata);
                    chk("addr_ok", {i_addr_ok, d_addr_ok}, {!sb[0].g_d, sb[0].g_d});
                    chk("busy_req", busy, 1);
                end
                a_cnt = alat;
            end
            if (i_addr_ok) i_valid = 1'b0;
            if (d_addr_ok) d_valid = 1'b0;
            pv = m_valid;
            if (m_valid && a_cnt >= 0) begin
                if (a_cnt == 0) begin m_addr_ok = 1'b1; d_cnt = dlat; a_cnt = -1; end
                else a_cnt--;
            end
            if (d_cnt >= 0) begin
                if (d_cnt == 0) begin
                    m_data_ok = 1'b1;
                    m_rdata = (sb.size() != 0) ? sb[0].rdata : 64'h0;
                    d_cnt = -1;
                end else d_cnt--;
            end
            #1;
            pdok = i_data_ok | d_data_ok;
            if (m_data_ok && !pdok) chk("dok_missing", 0, 1);
            if (pdok) begin
                if (sb.size() == 0) chk("spurious_dok", 1, 0);
                else begin
                    chk("dok_port", {i_data_ok, d_data_ok}, {!sb[0].g_d, sb[0].g_d});
                    chk("rdata", rdata, sb[0].rdata);
                    void'(sb.pop_front());
                end
            end
        end
        if (budget >= 80) begin
            chk("timeout", 1, 0);
            sb.delete();
            i_valid = 1'b0;
            d_valid = 1'b0;
        end
        @(negedge clk);
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        if (pdok) chk("idle_after_dok", {m_valid, busy}, 2'b00);
    endtask

    initial begin
        //        iv  ia                  dv  da                  sz    stb    wdata               al dl rd_i    rd_d
        vecs[0] = '{1, 64'h8000_0000,      0, 64'h0,              3'd0, 8'h00, 64'h0,              1, 3, 64'h13, 64'h0};
        vecs[1] = '{1, 64'h100,            1, 64'h8000_1000,      3'd3, 8'hFF, 64'hDEAD_BEEF,      0, 1, 64'h22, 64'h33};
        vecs[2] = '{1, 64'h104,            1, 64'h8000_1008,      3'd2, 8'h0F, 64'h1234_5678,      2, 0, 64'h44, 64'h55};
        vecs[3] = '{1, 64'h108,            1, 64'h8000_1010,      3'd1, 8'h03, 64'hCAFE,           0, 0, 64'h66, 64'h77};
        vecs[4] = '{0, 64'h0,              1, 64'h9000_0000,      3'd3, 8'hF0, 64'hA5A5_A5A5_0000, 0, 0, 64'h0,  64'h88};
        vecs[5] = '{1, 64'h200,            1, 64'h9000_0040,      3'd0, 8'h01, 64'h99,             1, 2, 64'hAA, 64'hBB};
        vecs[6] = '{0, 64'h0,              1, 64'h9000_0080,      3'd3, 8'h00, 64'h0,              0, 4, 64'h0,  64'hFEED_F00D};
        vecs[7] = '{1, 64'h8000_0010,      0, 64'h0,              3'd0, 8'h00, 64'h0,              3, 0, 64'h0BAD, 64'h0};

        // Reset held with a pending fetch: nothing may leak out
        i_valid = 1'b1;
        i_addr  = 64'h0000_1000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_outs", {m_valid, busy, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 6'b0);
        end
        rst = 1'b0;
        sb.push_back(mk_i(64'h0000_1000, 64'h5151));
        last_d = 1'b0;
        run(0, 1);

        for (int k = 0; k < 8; k++) begin
            push_req(vecs[k]);
            run(vecs[k].alat, vecs[k].dlat);
        end

        // Reset while waiting in RESP abandons the transaction; a late m_data_ok is ignored
        d_valid = 1'b1; d_addr = 64'h40; d_size = 3'd3; d_strobe = 8'h00; d_wdata = 64'h0;
        @(negedge clk);
        chk("rr_req", {m_valid, d_addr_ok, i_addr_ok}, 3'b110);
        d_valid = 1'b0;
        m_addr_ok = 1'b1;
        @(negedge clk);
        m_addr_ok = 1'b0;
        chk("rr_resp", {busy, m_valid}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rr_no_dok", {i_data_ok, d_data_ok}, 2'b00);
        @(negedge clk);
        chk("rr_rst", {busy, m_valid, i_data_ok, d_data_ok}, 4'b0);
        rst = 1'b0;
        m_data_ok = 1'b1;
        m_rdata = 64'h7777;
        #1;
        chk("late_dok", {i_data_ok, d_data_ok}, 2'b00);
        @(negedge clk);
        m_data_ok = 1'b0;
        chk("late_dok_idle", {busy, m_valid}, 2'b00);
        last_d = 1'b0;

        // Fresh tie after the abandoned transaction goes to data in either mode
        push_req(vecs[1]);
        run(1, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
